// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared state encoding and reference truth tables for the gate scanner.
package gate_tt_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_e;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
endpackage

// File: rtl/gate_tt_timer.sv
// gate_tt_timer: loadable down-counter; expire_o is high on the last cycle a vector is held.
module gate_tt_timer #(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   output logic expire_o
);
   localparam int W = $clog2(SETTLE + 1);
   localparam logic [W-1:0] LOAD = W'(SETTLE - 1);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (load_i) cnt_q <= LOAD;
      else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
   end
   assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/gate_tt_scanner.sv
// gate_tt_scanner: sweeps a 2-input gate through all vectors and checks its truth table.
module gate_tt_scanner
   import gate_tt_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             stop,
   input  logic [3:0]       exp_tt,
   output logic             gate_a,
   output logic             gate_b,
   input  logic             gate_y,
   output logic             busy,
   output logic             done,
   output logic [3:0]       tt,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
);
   state_e     state_q;
   logic [1:0] idx_q;
   logic       cont_q, stop_q, expire, load;
   logic [3:0] exp_q, work_q, work_d;
   always_comb begin
      work_d = work_q;
      work_d[idx_q] = gate_y;
   end
   assign load = (state_q == ST_IDLE && start)
              || (state_q == ST_SETTLE && expire && idx_q != 2'd3)
              || (state_q == ST_DONE && cont_q && !(stop_q || stop));
   gate_tt_timer #(.SETTLE(SETTLE)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .expire_o (expire)
   );
   // idx is forced back to 0 outside SETTLE so the gate pins can follow it directly.
   assign gate_a = idx_q[0];
   assign gate_b = idx_q[1];
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cont_q  <= 1'b0;
         stop_q  <= 1'b0;
         exp_q   <= '0;
         work_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         tt      <= '0;
         pass    <= 1'b0;
         err_cnt <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               state_q <= ST_SETTLE;
               idx_q   <= '0;
               busy    <= 1'b1;
               cont_q  <= cont;
               exp_q   <= exp_tt;
               err_cnt <= '0;
               stop_q  <= 1'b0;
            end
            ST_SETTLE: begin
               if (stop) stop_q <= 1'b1;
               if (expire) begin
                  work_q <= work_d;
                  idx_q  <= (idx_q == 2'd3) ? 2'd0 : idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q <= ST_DONE;
                     done    <= 1'b1;
                     tt      <= work_d;
                     pass    <= (work_d == exp_q);
                     if (work_d != exp_q && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               if (stop) stop_q <= 1'b1;
               state_q <= (cont_q && !(stop_q || stop)) ? ST_SETTLE : ST_IDLE;
               busy    <= cont_q && !(stop_q || stop);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_tt_scanner.sv
// tb_gate_tt_scanner: randomized and directed sweeps checked against a cycle-offset timing model.
module tb_gate_tt_scanner;
   import gate_tt_pkg::*;
   localparam int S = 2;
   localparam int P = 4 * S + 1;
   logic       clk = 0, rst = 1, start = 0, cont = 0, stop = 0;
   logic [3:0] exp_tt = 0, g_tt = TT_AND;
   logic       gate_a, gate_b, gate_y, busy, done, pass;
   logic [3:0] tt;
   logic [7:0] err_cnt;
   logic       a2, b2, y2, busy2, done2, pass2;
   logic [3:0] tt2;
   logic [1:0] err2;
   logic [3:0] tts [4] = '{TT_AND, TT_OR, TT_XOR, TT_NAND};
   logic [3:0] h_tt = 0;
   logic       h_pass = 0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign gate_y = g_tt[{gate_b, gate_a}];
   assign y2 = g_tt[{b2, a2}];

   gate_tt_scanner #(.SETTLE(S), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop), .exp_tt(exp_tt),
      .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y), .busy(busy), .done(done),
      .tt(tt), .pass(pass), .err_cnt(err_cnt));
   gate_tt_scanner #(.SETTLE(S), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .stop(stop), .exp_tt(exp_tt),
      .gate_a(a2), .gate_b(b2), .gate_y(y2), .busy(busy2), .done(done2),
      .tt(tt2), .pass(pass2), .err_cnt(err2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_vec", {gate_b, gate_a}, 0);
      chk("rst_tt", tt, 0); chk("rst_pass", pass, 0); chk("rst_err", err_cnt, 0);
      chk("rst_err2", err2, 0); chk("rst_busy2", busy2, 0);
   endtask

   // Expected behaviour is derived from the offset t (cycles since the accepted start).
   task automatic run(input bit c, input logic [3:0] g, input logic [3:0] e,
                      input int stop_at, input int glitch_at, input bit stop_with_start);
      int nsw, fails, p, v;
      bit bz, dn;
      g_tt = g; exp_tt = e; cont = c; start = 1; stop = stop_with_start;
      tick();
      start = 0; stop = 0; exp_tt = 4'($urandom);
      nsw = c ? (stop_at - 1) / P + 1 : 1;
      fails = 0;
      for (int t = 1; t <= nsw * P + 1; t++) begin
         p  = (t - 1) % P;
         bz = (t <= nsw * P);
         v  = (bz && p < 4 * S) ? p / S : 0;
         dn = bz && (p == 4 * S);
         if (dn) begin
            fails += (g != e) ? 1 : 0;
            h_tt = g;
            h_pass = (g == e);
         end
         chk("busy", busy, bz); chk("vec", {gate_b, gate_a}, v);
         chk("done", done, dn); chk("done2", done2, dn);
         chk("tt", tt, h_tt); chk("pass", pass, h_pass);
         chk("err_cnt", err_cnt, fails); chk("err_sat", err2, (fails > 3) ? 3 : fails);
         stop  = (t == stop_at);
         start = (t == glitch_at && t <= nsw * P);
         cont  = 1'($urandom);
         tick();
      end
      start = 0; stop = 0; cont = 0;
   endtask

   initial begin
      repeat (3) tick();
      rst = 0;
      chk_reset();
      stop = 1;
      tick();
      stop = 0;
      repeat (3) begin chk("idle_stop_busy", busy, 0); tick(); end
      run(0, TT_AND, TT_AND, 0, 0, 0);
      run(0, TT_AND, TT_XOR, 0, 0, 0);
      run(1, TT_AND, TT_XOR, 2 * P + 4, 0, 0);
      run(1, TT_OR, TT_NAND, 4 * P + 3, 0, 0);
      run(0, TT_XOR, TT_XOR, 0, 3, 0);
      run(0, TT_NAND, TT_NAND, 0, 0, 1);
      g_tt = TT_AND; exp_tt = TT_AND; cont = 0; start = 1;
      tick();
      start = 0;
      repeat (4) tick();
      chk("pre_rst_vec", {gate_b, gate_a}, 2'b10);
      rst = 1;
      tick();
      rst = 0;
      chk_reset();
      h_tt = 0; h_pass = 0;
      repeat (10) begin chk("post_rst_done", done, 0); chk("post_rst_busy", busy, 0); tick(); end
      run(0, TT_AND, TT_AND, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         logic [3:0] g, e;
         bit c;
         int sa;
         g  = tts[$urandom_range(0, 3)];
         e  = $urandom_range(0, 1) ? g : 4'($urandom);
         c  = 1'($urandom);
         sa = c ? int'($urandom_range(0, 2)) * P + int'($urandom_range(1, 4 * S))
                : int'($urandom_range(0, 4 * S));
         run(c, g, e, sa, int'($urandom_range(1, 4 * S)), 1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
